// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction-cache responder: line/word types, the
// default-geometry tag/index types and the controller state encoding.
package icache_responder_pkg;

  localparam int ICACHE_OFFSET_BITS = 4;
  localparam int ICACHE_INDEX_BITS  = 3;
  localparam int ICACHE_TAG_BITS    = 16 - ICACHE_OFFSET_BITS - ICACHE_INDEX_BITS;

  typedef logic [15:0]                  lc3b_word;
  typedef logic [127:0]                 lc3b_data;
  typedef logic [ICACHE_TAG_BITS-1:0]   lc3b_icache_tag;
  typedef logic [ICACHE_INDEX_BITS-1:0] lc3b_icache_index;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_responder_array.sv
// Direct-mapped line storage: per-set valid bit, tag and 128-bit line.
// Reads are combinational by index; writes happen on the load strobe.
// Reset clears only the valid bits; tags and data keep whatever they held.
module icache_responder_array
  import icache_responder_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int TAG_W    = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_SETS)-1:0] rd_index,
  output logic                        rd_valid,
  output logic [TAG_W-1:0]            rd_tag,
  output lc3b_data                    rd_data,
  input  logic                        load,
  input  logic [$clog2(NUM_SETS)-1:0] wr_index,
  input  logic [TAG_W-1:0]            wr_tag,
  input  lc3b_data                    wr_data
);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  lc3b_data            data_mem [NUM_SETS];

  // Valid bits: cleared together on reset, set when a line is installed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (load) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload: written on install, never reset.
  always_ff @(posedge clk) begin
    if (load) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Instruction-fetch responder: direct-mapped read-only line cache.
// Hits answer in the request cycle; misses fetch the line from pmem, then
// the following idle cycle re-evaluates the (possibly new) fetch address.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imem_address,
  input  logic        imem_action_stb,
  input  logic        imem_action_cyc,
  output lc3b_data    imem_rdata,
  output logic        imem_resp,
  output logic [15:0] pmem_address,
  output logic        pmem_read,
  input  lc3b_data    pmem_rdata,
  input  logic        pmem_resp
);

  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 16 - OW - IW;

  icache_state_e state;
  logic [15:0]   fill_addr;

  logic          req;
  logic          hit;
  logic          load;
  logic [IW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] fill_index;
  logic [TW-1:0] fill_tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  lc3b_data      rd_data;
  logic          unused_offset;

  assign req           = imem_action_stb & imem_action_cyc;
  assign req_index     = imem_address[OW+IW-1:OW];
  assign req_tag       = imem_address[15:OW+IW];
  assign fill_index    = fill_addr[OW+IW-1:OW];
  assign fill_tag      = fill_addr[15:OW+IW];
  assign unused_offset = ^imem_address[OW-1:0];

  icache_responder_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .load     (load),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_data  (pmem_rdata)
  );

  assign hit = rd_valid & (rd_tag == req_tag);

  // A pmem_resp only installs a line while a fill is outstanding; a late
  // response after reset arrives in IDLE and is dropped.
  assign load = (state == ST_FILL) & pmem_resp & ~rst;

  // Response is only ever given for the address presented this cycle.
  assign imem_resp  = (state == ST_IDLE) & req & hit & ~rst;
  assign imem_rdata = imem_resp ? rd_data : '0;

  assign pmem_address = fill_addr;

  // Miss/fill controller; pmem_read and the fill address are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pmem_read <= 1'b0;
      fill_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !hit) begin
            fill_addr <= {imem_address[15:OW], {OW{1'b0}}};
            pmem_read <= 1'b1;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          pmem_read <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed corner sequences, a table of hit/idle
// vectors, and a randomized run against a line-level cache model.
module tb_icache_responder;
  import icache_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_address;
  logic        stb;
  logic        cyc;
  lc3b_data    imem_rdata;
  logic        imem_resp;
  logic [15:0] pmem_address;
  logic        pmem_read;
  lc3b_data    pmem_rdata;
  logic        pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  // pmem responder state
  int   pmem_lat   = 3;
  int   rd_cnt     = 0;
  logic force_resp = 1'b0;

  icache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .imem_address    (imem_address),
    .imem_action_stb (stb),
    .imem_action_cyc (cyc),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory content: each line is tagged with its line number.
  function automatic lc3b_data line_of(input logic [15:0] a);
    return {{7{16'hAAAA}}, 4'h0, a[15:4]};
  endfunction

  task automatic check(input string name, input lc3b_data act, input lc3b_data exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, play pmem, sample at negedge.
  task automatic tick(input logic r, input logic [15:0] a, input logic s, input logic c);
    @(posedge clk);
    #1;
    rst          = r;
    imem_address = a;
    stb          = s;
    cyc          = c;
    if (force_resp) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {4{$urandom()}};
    end else if (pmem_read) begin
      rd_cnt++;
      if (rd_cnt >= pmem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(pmem_address);
        rd_cnt     = 0;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = {4{$urandom()}};
      end
    end else begin
      rd_cnt     = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
    end
    @(negedge clk);
  endtask

  // Full miss: miss cycle, lat fill cycles at the aligned address, then a hit.
  task automatic miss_fill(input logic [15:0] a, input int lat, input string name);
    int n;
    int bad;
    logic [15:0] line;
    line     = {a[15:4], 4'h0};
    pmem_lat = lat;
    n        = 0;
    bad      = 0;
    tick(1'b0, a, 1'b1, 1'b1);
    check({name, " miss resp/read"}, {imem_resp, pmem_read}, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, a, 1'b1, 1'b1);
      if (!pmem_read) break;
      n++;
      if (pmem_address !== line || imem_resp !== 1'b0) bad++;
    end
    check({name, " fill cycles"}, n, lat);
    check({name, " fill addr/resp errors"}, bad, 0);
    check({name, " hit resp"}, imem_resp, 1'b1);
    check({name, " hit rdata"}, imem_rdata, line_of(a));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        s;
    logic        c;
    logic        resp;
    logic        pread;
    lc3b_data    rdata;
  } vec_t;

  vec_t vecs[12];

  // random-phase model
  logic        m_valid [8];
  logic [15:0] m_line  [8];
  bit          m_fill;
  logic [15:0] m_fill_line;

  initial begin
    int n;
    int bad;
    logic [15:0] ra;
    logic        rs;
    logic        rc;

    rst          = 1'b1;
    imem_address = '0;
    stb          = 1'b0;
    cyc          = 1'b0;
    pmem_resp    = 1'b0;
    pmem_rdata   = '0;

    // Reset: no response while rst is high, outputs idle afterwards
    tick(1'b1, 16'h0012, 1'b1, 1'b1);
    check("resp during rst", imem_resp, 1'b0);
    tick(1'b1, 16'h0012, 1'b1, 1'b1);
    check("resp during rst 2", imem_resp, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    check("post-rst resp/read", {imem_resp, pmem_read}, 2'b00);
    check("post-rst pmem_address", pmem_address, 16'h0000);
    check("post-rst rdata", imem_rdata, 128'h0);

    // Cold miss at 0x0012 with a 3-cycle pmem
    miss_fill(16'h0012, 3, "cold");
    check("cold literal rdata", imem_rdata,
          128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001);

    // Hit stream and idle-bus vectors over the line at 0x0010
    for (int i = 0; i < 8; i++)
      vecs[i] = '{16'h0010 + 16'(2 * i), 1'b1, 1'b1, 1'b1, 1'b0, line_of(16'h0010)};
    vecs[8]  = '{16'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 128'h0};
    vecs[9]  = '{16'h0018, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vecs[10] = '{16'h001C, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0};
    vecs[11] = '{16'h001E, 1'b1, 1'b1, 1'b1, 1'b0, line_of(16'h0010)};
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, vecs[i].addr, vecs[i].s, vecs[i].c);
      check($sformatf("vec%0d resp/read", i), {imem_resp, pmem_read}, {vecs[i].resp, vecs[i].pread});
      check($sformatf("vec%0d rdata", i), imem_rdata, vecs[i].rdata);
    end

    // Conflict eviction on set 1, then the evicted line misses again
    miss_fill(16'h0090, 2, "evict 0x0090");
    miss_fill(16'h0010, 2, "refetch 0x0010");

    // Address change in the middle of a fill
    pmem_lat = 3;
    tick(1'b0, 16'h0020, 1'b1, 1'b1);
    check("switch miss resp", imem_resp, 1'b0);
    tick(1'b0, 16'h0020, 1'b1, 1'b1);
    check("switch fill1 read/addr", {pmem_read, pmem_address}, {1'b1, 16'h0020});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'h0030, 1'b1, 1'b1);
      if (!pmem_read) break;
      if (pmem_address !== 16'h0020 || imem_resp !== 1'b0) bad++;
    end
    check("switch fill errors", bad, 0);
    check("switch new miss resp/read", {imem_resp, pmem_read}, 2'b00);
    tick(1'b0, 16'h0030, 1'b1, 1'b1);
    check("switch new fill read/addr", {pmem_read, pmem_address}, {1'b1, 16'h0030});
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'h0030, 1'b1, 1'b1);
      if (!pmem_read) break;
    end
    check("switch 0x0030 hit", {imem_resp, imem_rdata}, {1'b1, line_of(16'h0030)});
    tick(1'b0, 16'h0020, 1'b1, 1'b1);
    check("switch 0x0020 installed", {imem_resp, imem_rdata}, {1'b1, line_of(16'h0020)});

    // Reset in the second fill cycle, then a late pmem_resp
    pmem_lat = 10;
    tick(1'b0, 16'h0040, 1'b1, 1'b1);
    check("rstfill miss resp", imem_resp, 1'b0);
    tick(1'b0, 16'h0040, 1'b1, 1'b1);
    tick(1'b1, 16'h0010, 1'b1, 1'b1);
    check("rstfill resp during rst", imem_resp, 1'b0);
    force_resp = 1'b1;
    tick(1'b0, 16'h0010, 1'b0, 1'b0);
    force_resp = 1'b0;
    check("rstfill read dropped", {pmem_read, imem_resp}, 2'b00);
    miss_fill(16'h0040, 2, "rstfill 0x0040");
    miss_fill(16'h0010, 2, "rstfill 0x0010");

    // Randomized run against a line-level model
    tick(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    m_fill = 1'b0;
    m_fill_line = '0;
    ra = 16'h0000;
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] line;
      logic [2:0]  idx;
      logic        exp_resp;
      lc3b_data    exp_rdata;
      if ($urandom_range(0, 9) < 3) ra = 16'($urandom_range(0, 31) << 4) | 16'($urandom_range(0, 15));
      rs = ($urandom_range(0, 9) != 0);
      rc = ($urandom_range(0, 9) != 0);
      tick(1'b0, ra, rs, rc);
      line = {ra[15:4], 4'h0};
      idx  = ra[6:4];
      exp_resp  = 1'b0;
      exp_rdata = '0;
      if (m_fill) begin
        check("rand fill ctrl", {imem_resp, pmem_read, pmem_address}, {1'b0, 1'b1, m_fill_line});
        check("rand fill rdata", imem_rdata, 128'h0);
        if (pmem_resp) begin
          m_valid[m_fill_line[6:4]] = 1'b1;
          m_line[m_fill_line[6:4]]  = m_fill_line;
          m_fill = 1'b0;
        end
      end else begin
        if (rs && rc && m_valid[idx] && m_line[idx] == line) begin
          exp_resp  = 1'b1;
          exp_rdata = line_of(line);
        end else if (rs && rc) begin
          m_fill      = 1'b1;
          m_fill_line = line;
          pmem_lat    = $urandom_range(1, 4);
        end
        check("rand idle ctrl", {imem_resp, pmem_read}, {exp_resp, 1'b0});
        check("rand idle rdata", imem_rdata, exp_rdata);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
